// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM-stage sequencer and data memory.
// The master side issues requests; the slave side acknowledges and returns read data.
interface mem_access_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: checks alignment, runs the data-memory req/ack handshake while
// stalling the pipeline, forms store byte-enables/data and feeds the load shifter.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_load_sel,
  input  logic [1:0]        ex_store_sel,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic              flush,
  mem_access_ctrl_if.master dmem,
  output logic [1:0]        shf_addr,
  output logic [2:0]        shf_load_sel,
  output logic [31:0]       shf_mem_data,
  output logic              ld_valid,
  output logic              stall,
  output logic              addr_err,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        op_present, aligned, accept, timeout_hit;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  logic        we_reg, is_load_reg, kill_reg, bus_err_reg;
  logic [31:0] addr_reg, wdata_reg, shf_data_reg;
  logic [3:0]  be_reg;
  logic [1:0]  shf_addr_reg;
  logic [2:0]  shf_sel_reg;
  logic [7:0]  cnt_reg;

  assign op_present = ex_valid & (ex_is_load | ex_is_store) & ~flush;

  // Alignment check and store lane formation from the presented op.
  always_comb begin
    aligned    = 1'b1;
    be_next    = 4'b0000;
    wdata_next = ex_wdata;
    if (ex_is_load) begin
      case (ex_load_sel)
        3'd2, 3'd3: aligned = ~ex_addr[0];
        3'd4:       aligned = (ex_addr[1:0] == 2'b00);
        default:    aligned = 1'b1;
      endcase
    end else begin
      case (ex_store_sel)
        2'd0: begin
          aligned    = 1'b1;
          be_next    = 4'b0001 << ex_addr[1:0];
          wdata_next = {4{ex_wdata[7:0]}};
        end
        2'd1: begin
          aligned    = ~ex_addr[0];
          be_next    = ex_addr[1] ? 4'b1100 : 4'b0011;
          wdata_next = {2{ex_wdata[15:0]}};
        end
        default: begin
          aligned    = (ex_addr[1:0] == 2'b00);
          be_next    = 4'b1111;
          wdata_next = ex_wdata;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    addr_err    = 1'b0;
    ld_valid    = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: begin
        if (op_present) begin
          if (aligned) begin
            accept     = 1'b1;
            state_next = REQ;
          end else begin
            addr_err = 1'b1;
          end
        end
      end
      REQ: begin
        // An ack arriving on the timeout cycle still completes the access.
        if (dmem.dmem_ack) begin
          state_next = DONE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        ld_valid   = is_load_reg & ~kill_reg & ~bus_err_reg & ~flush;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    stall = accept | (state_reg == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg       <= 1'b0;
      is_load_reg  <= 1'b0;
      kill_reg     <= 1'b0;
      bus_err_reg  <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      be_reg       <= '0;
      shf_addr_reg <= '0;
      shf_sel_reg  <= '0;
      shf_data_reg <= '0;
      cnt_reg      <= '0;
    end else begin
      if (accept) begin
        we_reg       <= ex_is_store;
        is_load_reg  <= ex_is_load;
        kill_reg     <= 1'b0;
        addr_reg     <= {ex_addr[31:2], 2'b00};
        be_reg       <= be_next;
        wdata_reg    <= wdata_next;
        shf_addr_reg <= ex_addr[1:0];
        shf_sel_reg  <= ex_load_sel;
      end else if ((state_reg == REQ) && flush) begin
        kill_reg <= 1'b1;
      end
      if ((state_reg == REQ) && dmem.dmem_ack && is_load_reg)
        shf_data_reg <= dmem.dmem_rdata;
      cnt_reg     <= ((state_reg == REQ) && !dmem.dmem_ack) ? cnt_reg + 8'd1 : 8'd0;
      bus_err_reg <= timeout_hit;
    end
  end

  assign dmem.dmem_req   = (state_reg == REQ);
  assign dmem.dmem_we    = we_reg;
  assign dmem.dmem_addr  = addr_reg;
  assign dmem.dmem_be    = be_reg;
  assign dmem.dmem_wdata = wdata_reg;
  assign shf_addr        = shf_addr_reg;
  assign shf_load_sel    = shf_sel_reg;
  assign shf_mem_data    = shf_data_reg;
  assign bus_err         = bus_err_reg;

endmodule
